rst_seq_gen: RTL and testbench
==============================

Name: rst_seq_gen

Overview:
Reset sequencer that drives the active-high synchronous `sync_reset` inputs of downstream flip-flops and datapaths. It takes the board-level asynchronous active-low reset and a software reset request, and produces NUM_OUT active-high synchronous reset outputs. Outputs assert together and release one at a time in a staggered order, so all blocks see a clean, glitch-free release.

Parameters:
SYNC_STAGES, 2, depth of the reset-release synchronizer chain (legal range >=2)
HOLD_CYCLES, 16, cycles all outputs stay asserted after synchronized release (>=1)
STAGGER, 4, cycles between successive output releases (>=1)
NUM_OUT, 3, number of synchronous reset outputs (1..16)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
sw_rst_req  input  1  synchronous software reset request, level sampled each edge
sw_rst_ack  output  1  one-cycle pulse acknowledging an accepted sw_rst_req
sync_reset  output  NUM_OUT  active-high synchronous resets; bit i released i-th
rst_done  output  1  high when every sync_reset bit is released

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low. Every flop in the block is cleared by `rst_n`; no other async path exists.
- While `rst_n`=0, outputs take these values immediately, without waiting for a clock:
  - `sync_reset` = all ones, `rst_done`=0, `sw_rst_ack`=0.
  - Synchronizer chain = 0, FSM = ASSERT, counters = 0.
- Synchronizer: SYNC_STAGES flops shift in 1 after `rst_n` rises. `rst_sync` is the last stage.
- Edge numbering: edge 1 is the first posedge after `rst_n` rises. `rst_sync` is 1 after edge SYNC_STAGES.
- FSM states: ASSERT, HOLD, RELEASE, RUN.
- ASSERT:
  - All outputs asserted.
  - Moves to HOLD on the edge where `rst_sync`=1 (edge SYNC_STAGES+1); hold counter = 0.
- HOLD:
  - Counter increments each edge.
  - After HOLD_CYCLES edges in HOLD, on that same edge: clear `sync_reset[0]`, go to RELEASE with index = 1 and stagger counter = 0.
  - If NUM_OUT=1, go straight to RUN instead.
- RELEASE:
  - Stagger counter counts STAGGER edges.
  - On the STAGGER-th edge: clear `sync_reset[index]`, reset the counter, increment index.
  - When the last bit clears, go to RUN on that same edge.
- RUN:
  - `rst_done`=1, registered and rising on the same edge as the last release.
- Release timing after `rst_n`: `sync_reset[i]` falls at edge SYNC_STAGES+1+HOLD_CYCLES+i*STAGGER.
- Software reset:
  - `sw_rst_req`=1 sampled in RUN at edge e. On edge e: all `sync_reset` bits go to 1, `rst_done`=0, `sw_rst_ack`=1 for exactly one cycle, FSM goes to HOLD with counter = 0. The synchronizer is untouched.
  - Bit i then falls at edge e+HOLD_CYCLES+i*STAGGER.
  - `sw_rst_req` in any state other than RUN is ignored: no ack, no restart of the sequence.
  - A request held high through the whole sequence is accepted again at the first edge in RUN, giving a back-to-back sequence.
- Outputs never glitch:
  - Bits only transition from registered state.
  - Release order is strictly bit 0 to bit NUM_OUT-1.
  - A released bit never re-asserts except via `rst_n` or an accepted software reset.
- Reset mid-operation: `rst_n` low in any state, even for a pulse shorter than one clock, asynchronously forces the full reset values. The sequence restarts from edge 1 after release.
- Counter widths: `$clog2` of max(HOLD_CYCLES, STAGGER)+1 and of NUM_OUT+1. No wrap is reachable in legal use.

Test Plan:
- Power-up: defaults; `rst_n` low for 3 cycles then high. Required response:
  - `sync_reset`=3'b111 throughout the low period, with no clock needed.
  - Bit 0 falls at edge 19, bit 1 at edge 23, bit 2 at edge 27.
  - `rst_done` rises at edge 27.
- Async assert: in RUN, drive `rst_n` low mid-cycle → `sync_reset`=3'b111 and `rst_done`=0 before the next clock edge. Release `rst_n` → same 19/23/27 timeline.
- Software reset: in RUN, 1-cycle `sw_rst_req` sampled at edge 100. Required response:
  - `sw_rst_ack`=1 for one cycle only.
  - `sync_reset`=3'b111 after edge 100.
  - Bits fall at edges 116, 120, 124; `rst_done` rises at edge 124.
- Ignored request: `sw_rst_req` pulsed at edge 10 and edge 21 during the power-up sequence → no ack, timeline unchanged at 19/23/27.
- Reset mid-sequence: `rst_n` low at edge 21 (bit 0 released, bits 1–2 held) → all bits asserted immediately. Re-release `rst_n` → full fresh timeline from edge 1.
- Parameter sweep: NUM_OUT=1, HOLD_CYCLES=1, SYNC_STAGES=3 → `sync_reset[0]` and `rst_done` change together at edge 5. Software reset at edge e releases at e+1.

Source files
------------

// File: rtl/rst_seq_gen.sv
// Reset sequencer: synchronizes the release of an async active-low reset, then
// releases NUM_OUT active-high synchronous resets one at a time in index order.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_ASSERT  | all outputs asserted, waiting for the synchronized reset release
// ST_HOLD    | all outputs asserted, counting HOLD_CYCLES edges
// ST_RELEASE | releasing bit idx after every STAGGER edges
// ST_RUN     | all bits released, rst_done high, software request accepted
module rst_seq_gen #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGGER     = 4,
  parameter int NUM_OUT     = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sw_rst_req,
  output logic               sw_rst_ack,
  output logic [NUM_OUT-1:0] sync_reset,
  output logic               rst_done
);

  localparam int CNT_MAX = (HOLD_CYCLES > STAGGER) ? HOLD_CYCLES : STAGGER;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = $clog2(NUM_OUT + 1);

  localparam logic [CW-1:0]      HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0]      STAG_LAST = CW'(STAGGER - 1);
  localparam logic [IW-1:0]      IDX_LAST  = IW'(NUM_OUT - 1);
  localparam logic [NUM_OUT-1:0] BIT0      = NUM_OUT'(1);

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 rst_sync;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [NUM_OUT-1:0]   sync_reset_d;
  logic                 rst_done_d;
  logic                 sw_rst_ack_d;

  assign rst_sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      state_q    <= ST_ASSERT;
      cnt_q      <= '0;
      idx_q      <= '0;
      sync_reset <= '1;
      rst_done   <= 1'b0;
      sw_rst_ack <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], 1'b1};
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      sync_reset <= sync_reset_d;
      rst_done   <= rst_done_d;
      sw_rst_ack <= sw_rst_ack_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    sync_reset_d = sync_reset;
    rst_done_d   = rst_done;
    sw_rst_ack_d = 1'b0;
    case (state_q)
      ST_ASSERT: begin
        sync_reset_d = '1;
        rst_done_d   = 1'b0;
        if (rst_sync) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          sync_reset_d = sync_reset & ~BIT0;
          cnt_d        = '0;
          if (NUM_OUT == 1) begin
            state_d    = ST_RUN;
            rst_done_d = 1'b1;
          end else begin
            state_d = ST_RELEASE;
            idx_d   = IW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RELEASE: begin
        if (cnt_q == STAG_LAST) begin
          sync_reset_d = sync_reset & ~(BIT0 << idx_q);
          cnt_d        = '0;
          idx_d        = idx_q + IW'(1);
          if (idx_q == IDX_LAST) begin
            state_d    = ST_RUN;
            rst_done_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RUN: begin
        // Restart from HOLD; the synchronizer stays released.
        if (sw_rst_req) begin
          sync_reset_d = '1;
          rst_done_d   = 1'b0;
          sw_rst_ack_d = 1'b1;
          state_d      = ST_HOLD;
          cnt_d        = '0;
        end
      end
      default: state_d = ST_ASSERT;
    endcase
  end

endmodule

// File: tb/tb_rst_seq_gen.sv
// Bench for rst_seq_gen: default instance (a) and a NUM_OUT=1/HOLD=1/SYNC=3 instance (b),
// both compared every edge against a release-time model.
module tb_rst_seq_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req_a = 1'b0;
  logic       req_b = 1'b0;
  logic       ack_a, ack_b, done_a, done_b;
  logic [2:0] sr_a;
  logic [0:0] sr_b;

  int checks = 0;
  int errors = 0;

  // model state: k = edges since rst_n rose; base = edge at which HOLD began
  int          k = 0;
  int          base_a = 3, base_b = 4;
  logic [15:0] m_bits_a = '1, m_bits_b = '1;
  logic        m_done_a = 1'b0, m_done_b = 1'b0;
  logic        m_ack_a = 1'b0, m_ack_b = 1'b0;
  int          acks_seen_a = 0;

  rst_seq_gen u_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw_rst_req (req_a),
    .sw_rst_ack (ack_a),
    .sync_reset (sr_a),
    .rst_done   (done_a)
  );

  rst_seq_gen #(.SYNC_STAGES(3), .HOLD_CYCLES(1), .STAGGER(4), .NUM_OUT(1)) u_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw_rst_req (req_b),
    .sw_rst_ack (ack_b),
    .sync_reset (sr_b),
    .rst_done   (done_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at k=%0d: got %0h expected %0h", name, k, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_bits(input int kk, input int b, input int h,
                                           input int stg, input int n);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i] = (kk < b + h + i * stg);
    return r;
  endfunction

  always @(negedge rst_n) begin
    k = 0;
    base_a = 3;
    base_b = 4;
    m_bits_a = '1;
    m_bits_b = '1;
    m_done_a = 1'b0;
    m_done_b = 1'b0;
    m_ack_a = 1'b0;
    m_ack_b = 1'b0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      k++;
      m_ack_a = req_a && m_done_a;
      if (m_ack_a) base_a = k;
      m_ack_b = req_b && m_done_b;
      if (m_ack_b) base_b = k;
      m_bits_a = exp_bits(k, base_a, 16, 4, 3);
      m_done_a = (k >= base_a + 16 + 2 * 4);
      m_bits_b = exp_bits(k, base_b, 1, 4, 1);
      m_done_b = (k >= base_b + 1);
    end
    #1;
    chk("a_sync_reset", 32'(sr_a), 32'(m_bits_a[2:0]));
    chk("a_rst_done", 32'(done_a), 32'(m_done_a));
    chk("a_sw_rst_ack", 32'(ack_a), 32'(m_ack_a));
    chk("b_sync_reset", 32'(sr_b), 32'(m_bits_b[0]));
    chk("b_rst_done", 32'(done_b), 32'(m_done_b));
    chk("b_sw_rst_ack", 32'(ack_b), 32'(m_ack_b));
    if (ack_a) acks_seen_a++;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Walks edges 1..upto after an rst_n release, checking the fixed release edges.
  task automatic run_timeline(input bit poke_req, input int upto);
    for (int e = 1; e <= upto; e++) begin
      if (poke_req && (e == 10 || e == 21)) req_a = 1'b1;
      step();
      req_a = 1'b0;
      if (poke_req && (e == 10 || e == 21)) chk("ignored_req_ack", 32'(ack_a), 32'd0);
      case (e)
        4:  begin chk("b_pre_rel", 32'(sr_b), 32'd1); chk("b_pre_done", 32'(done_b), 32'd0); end
        5:  begin chk("b_rel_e5", 32'(sr_b), 32'd0); chk("b_done_e5", 32'(done_b), 32'd1); end
        18: chk("a_e18", 32'(sr_a), 32'h7);
        19: chk("a_e19", 32'(sr_a), 32'h6);
        21: chk("a_e21", 32'(sr_a), 32'h6);
        22: chk("a_e22", 32'(sr_a), 32'h6);
        23: chk("a_e23", 32'(sr_a), 32'h4);
        26: begin chk("a_e26", 32'(sr_a), 32'h4); chk("a_done_e26", 32'(done_a), 32'd0); end
        27: begin chk("a_e27", 32'(sr_a), 32'h0); chk("a_done_e27", 32'(done_a), 32'd1); end
        default: ;
      endcase
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("por_no_clk_a", 32'(sr_a), 32'h7);
    chk("por_no_clk_done", 32'(done_a), 32'd0);
    chk("por_no_clk_ack", 32'(ack_a), 32'd0);
    chk("por_no_clk_b", 32'(sr_b), 32'd1);
    repeat (3) step();
    chk("por_held_a", 32'(sr_a), 32'h7);
    rst_n = 1'b1;
    run_timeline(1'b1, 30);

    // software reset on the single-output instance: release one edge later
    repeat (9) step();
    req_b = 1'b1;
    step();
    req_b = 1'b0;
    chk("b_sw_assert", 32'(sr_b), 32'd1);
    chk("b_sw_ack", 32'(ack_b), 32'd1);
    step();
    chk("b_sw_release", 32'(sr_b), 32'd0);
    chk("b_sw_done", 32'(done_b), 32'd1);
    chk("b_sw_ack_gone", 32'(ack_b), 32'd0);

    // software reset on instance a sampled at edge 100
    while (k < 99) step();
    req_a = 1'b1;
    step();
    req_a = 1'b0;
    chk("sw_ack_e100", 32'(ack_a), 32'd1);
    chk("sw_assert_e100", 32'(sr_a), 32'h7);
    chk("sw_done_e100", 32'(done_a), 32'd0);
    for (int e = 101; e <= 126; e++) begin
      step();
      case (e)
        101: chk("sw_ack_e101", 32'(ack_a), 32'd0);
        115: chk("sw_e115", 32'(sr_a), 32'h7);
        116: chk("sw_e116", 32'(sr_a), 32'h6);
        119: chk("sw_e119", 32'(sr_a), 32'h6);
        120: chk("sw_e120", 32'(sr_a), 32'h4);
        123: begin chk("sw_e123", 32'(sr_a), 32'h4); chk("sw_done_e123", 32'(done_a), 32'd0); end
        124: begin chk("sw_e124", 32'(sr_a), 32'h0); chk("sw_done_e124", 32'(done_a), 32'd1); end
        default: ;
      endcase
    end

    // async assert mid-cycle, shorter than a clock period
    rst_n = 1'b0;
    #1;
    chk("async_sr_a", 32'(sr_a), 32'h7);
    chk("async_done_a", 32'(done_a), 32'd0);
    chk("async_sr_b", 32'(sr_b), 32'd1);
    #2 rst_n = 1'b1;
    run_timeline(1'b0, 30);

    // reset during the staggered release
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    run_timeline(1'b0, 21);
    rst_n = 1'b0;
    #1;
    chk("mid_seq_sr_a", 32'(sr_a), 32'h7);
    chk("mid_seq_done_a", 32'(done_a), 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    run_timeline(1'b0, 30);

    // request held high: back-to-back sequences, one ack per 25 edges
    acks_seen_a = 0;
    req_a = 1'b1;
    repeat (80) step();
    req_a = 1'b0;
    chk("b2b_ack_count", 32'(acks_seen_a), 32'd4);

    // randomized requests and reset pulses against the model
    for (int i = 0; i < 3000; i++) begin
      req_a = ($urandom_range(0, 7) == 0);
      req_b = ($urandom_range(0, 3) == 0);
      step();
      case ($urandom_range(0, 299))
        0: begin rst_n = 1'b0; #3 rst_n = 1'b1; end
        1: begin rst_n = 1'b0; step(); step(); rst_n = 1'b1; end
        default: ;
      endcase
    end
    req_a = 1'b0;
    req_b = 1'b0;
    repeat (40) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
